// File: rtl/calc_pkg.sv
// Shared encodings for the calculator input controller: entry-step states
// and operator select codes driven to the external calculator.
package calc_pkg;

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_OP  = 2'b10,
    S_RES = 2'b11
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

endpackage

// File: rtl/btn_edge.sv
// Button synchronizer plus registered rising-edge detector producing a
// one-cycle press pulse; a level already high out of reset is ignored.
module btn_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   prev_q;
  logic                   armed_q;
  logic                   pulse_q;
  logic                   sync_last;
  logic                   vld_last;

  assign sync_last = sync_q[SYNC_STAGES-1];
  // vld marks the last stage as holding a real sample rather than reset zeros.
  assign vld_last  = vld_q[SYNC_STAGES-1];

  // NOTE: non-blocking assignments so every flop samples pre-edge values;
  // blocking here would collapse the synchronizer chain into one stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= '0;
      vld_q   <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= (sync_q << 1) | SYNC_STAGES'(i_btn);
      vld_q   <= (vld_q << 1) | SYNC_STAGES'(1'b1);
      prev_q  <= sync_last;
      // A press only counts once the button has genuinely been seen low.
      if (vld_last && !sync_last) armed_q <= 1'b1;
      pulse_q <= vld_last & armed_q & sync_last & ~prev_q;
    end
  end

  assign o_pulse = pulse_q;

endmodule

// File: rtl/calc_input_ctrl.sv
// Three-button operand/operator entry FSM for an external calculator:
// A -> B -> OP -> RES, capturing the calculator result on entering RES.
module calc_input_ctrl
  import calc_pkg::*;
#(
  parameter int DW          = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_btn_up,
  input  logic          i_btn_next,
  input  logic          i_btn_clr,
  output logic [DW-1:0] o_a,
  output logic [DW-1:0] o_b,
  output logic [1:0]    o_sel,
  input  logic [DW-1:0] i_result,
  output logic [DW-1:0] o_disp,
  output logic [1:0]    o_state,
  output logic          o_valid
);

  logic up_p, next_p, clr_p;

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_up (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_up),   .o_pulse(up_p)
  );
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_next (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_next), .o_pulse(next_p)
  );
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clr (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_clr),  .o_pulse(clr_p)
  );

  state_e        state_q, state_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, res_q, res_d, disp_q, disp_d;
  logic [1:0]    sel_q, sel_d;
  logic          valid_q, valid_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= OP_ADD;
      res_q   <= '0;
      disp_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      disp_q  <= disp_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: every signal gets a hold default before the case statements so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    res_d   = res_q;
    valid_d = 1'b0;
    // Priority clr > next > up; lower-priority pulses in the same cycle are dropped.
    if (clr_p) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      sel_d   = OP_ADD;
      res_d   = '0;
    end else if (next_p) begin
      case (state_q)
        S_A:     state_d = S_B;
        S_B:     state_d = S_OP;
        S_OP: begin
          state_d = S_RES;
          res_d   = i_result;
          valid_d = 1'b1;
        end
        default: begin
          state_d = S_A;
          res_d   = '0;
        end
      endcase
    end else if (up_p) begin
      case (state_q)
        S_A:     a_d   = a_q + 1'b1;
        S_B:     b_d   = b_q + 1'b1;
        S_OP:    sel_d = sel_q + 2'd1;
        default: ;
      endcase
    end
  end

  // Display follows the next state so it changes on the same edge as o_state.
  always_comb begin
    disp_d = '0;
    case (state_d)
      S_A:     disp_d = a_d;
      S_B:     disp_d = b_d;
      S_OP:    disp_d = DW'(sel_d);
      default: disp_d = res_d;
    endcase
  end

  assign o_a     = a_q;
  assign o_b     = b_q;
  assign o_sel   = sel_q;
  assign o_disp  = disp_q;
  assign o_state = state_q;
  assign o_valid = valid_q;

endmodule
